// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, default reset PC and
// the IF/ID pipeline record consumed by the decode stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, inst: NOP_INST, valid: 1'b0};

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: asynchronous active-low reset to RESET_PC,
// loads i_load_val on edges where i_load_en is set, otherwise holds.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load_en,
  input  logic [XLEN-1:0] i_load_val,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load_en) begin
      r_pc <= i_load_val;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives imem_adrs and fills the IF/ID
// register. Define IF_PERF_CNT_EN to add fetch_cnt/stall_cnt counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            freeze,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            flush,
  output logic [XLEN-1:0] imem_adrs,
  input  logic [XLEN-1:0] imem_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_inst,
`ifdef IF_PERF_CNT_EN
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt,
`endif
  output logic            if_id_valid
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_next_seq;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_pc_load_en;
  logic [XLEN-1:0] w_pc_load_val;
  logic            w_fetch;
  if_id_t          r_if_id;

  assign w_pc_next_seq = w_pc + XLEN'(PC_STEP);
  // Low address bits of a redirect target are dropped to keep fetches aligned.
  assign w_redirect_pc = branch_addr & ~32'h0000_0003;
  assign w_fetch       = !branch_taken && !flush && !freeze;

  // Redirect wins; otherwise the PC advances unless frozen (flush still advances).
  assign w_pc_load_en  = branch_taken || !freeze;
  assign w_pc_load_val = branch_taken ? w_redirect_pc : w_pc_next_seq;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_en  (w_pc_load_en),
    .i_load_val (w_pc_load_val),
    .o_pc       (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (branch_taken || flush) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (!freeze) begin
      r_if_id <= '{pc: w_pc_next_seq, inst: imem_inst, valid: 1'b1};
    end
  end

  assign imem_adrs   = w_pc;
  assign if_id_pc    = r_if_id.pc;
  assign if_id_inst  = r_if_id.inst;
  assign if_id_valid = r_if_id.valid;

`ifdef IF_PERF_CNT_EN
  logic [XLEN-1:0] r_fetch_cnt;
  logic [XLEN-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (freeze && !branch_taken) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  logic w_fetch_unused;
  assign w_fetch_unused = w_fetch;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: sequential fetch, freeze, redirect, flush,
// PC wrap-around (second instance) and asynchronous reset mid-freeze.
module tb_if_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, freeze, branch_taken, flush;
  logic [31:0] branch_addr;
  logic [31:0] imem_adrs, imem_inst, if_id_pc, if_id_inst;
  logic        if_id_valid;

  logic        rst_n_w;
  logic [31:0] imem_adrs_w, imem_inst_w, if_id_pc_w, if_id_inst_w;
  logic        if_id_valid_w;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  // Bench memory: the word at address A is A + 0x1000.
  assign imem_inst   = imem_adrs + 32'h1000;
  assign imem_inst_w = imem_adrs_w + 32'h1000;

  if_stage u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .flush        (flush),
    .imem_adrs    (imem_adrs),
    .imem_inst    (imem_inst),
    .if_id_pc     (if_id_pc),
    .if_id_inst   (if_id_inst),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .if_id_valid  (if_id_valid)
  );

  if_stage #(
    .RESET_PC (32'hFFFF_FFF8),
    .PC_STEP  (4)
  ) u_dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n_w),
    .freeze       (1'b0),
    .branch_taken (1'b0),
    .branch_addr  (32'h0),
    .flush        (1'b0),
    .imem_adrs    (imem_adrs_w),
    .imem_inst    (imem_inst_w),
    .if_id_pc     (if_id_pc_w),
    .if_id_inst   (if_id_inst_w),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt    (fetch_cnt_w),
    .stall_cnt    (stall_cnt_w),
`endif
    .if_id_valid  (if_id_valid_w)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                             input logic [31:0] inst, input logic valid);
    check_eq({tag, ".adrs"},  imem_adrs, pc);
    check_eq({tag, ".ifpc"},  if_id_pc, ipc);
    check_eq({tag, ".inst"},  if_id_inst, inst);
    check_eq({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
  endtask

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0; flush = 1'b0; branch_addr = '0;
    #12;
    check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_state("run0", 32'h0, 32'h0, 32'h0, 1'b0);

    // Sequential fetch
    step(); check_state("run1", 32'h4, 32'h4, 32'h1000, 1'b1);
`ifdef IF_PERF_CNT_EN
    check_eq("fetch_cnt1", fetch_cnt, 32'd1);
`endif
    step(); check_state("run2", 32'h8, 32'h8, 32'h1004, 1'b1);

    // Freeze three cycles at pc=8
    freeze = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step(); check_state("frz", 32'h8, 32'h8, 32'h1004, 1'b1);
    end
`ifdef IF_PERF_CNT_EN
    check_eq("stall_cnt3", stall_cnt, 32'd3);
    check_eq("fetch_cnt_frz", fetch_cnt, 32'd2);
`endif
    freeze = 1'b0;
    step(); check_state("unfrz", 32'hC, 32'hC, 32'h1008, 1'b1);

    // Redirect to unaligned target while frozen: redirect wins
    branch_taken = 1'b1; branch_addr = 32'h0000_0043; freeze = 1'b1;
    step(); check_state("br", 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; freeze = 1'b0;
    step(); check_state("br_next", 32'h44, 32'h44, 32'h1040, 1'b1);

    // Flush alone at pc=16
    branch_taken = 1'b1; branch_addr = 32'h10;
    step(); check_state("br16", 32'h10, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0; flush = 1'b1;
    step(); check_state("flush", 32'h14, 32'h0, 32'h0, 1'b0);
    flush = 1'b0;
    step(); check_state("post_flush", 32'h18, 32'h18, 32'h1014, 1'b1);

    // Flush with freeze: bubble, PC held
    flush = 1'b1; freeze = 1'b1;
    step(); check_state("flush_frz", 32'h18, 32'h0, 32'h0, 1'b0);
    flush = 1'b0; freeze = 1'b0;
    step(); check_state("post_ff", 32'h1C, 32'h1C, 32'h1018, 1'b1);

    // Async reset pulse during freeze at pc=0x24
    branch_taken = 1'b1; branch_addr = 32'h24;
    step();
    branch_taken = 1'b0;
    step(); check_state("pre_rst", 32'h28, 32'h28, 32'h1024, 1'b1);
    branch_taken = 1'b1; branch_addr = 32'h24;
    step();
    branch_taken = 1'b0; freeze = 1'b1;
    step(); check_eq("frz24.adrs", imem_adrs, 32'h24);
    #2 rst_n = 1'b0;
    #1 check_state("mid_rst", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    check_eq("rst_fetch_cnt", fetch_cnt, 32'd0);
    check_eq("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    #1 rst_n = 1'b1; freeze = 1'b0;
    step(); check_state("after_rst", 32'h4, 32'h4, 32'h1000, 1'b1);

    // PC wrap on the RESET_PC=FFFF_FFF8 instance
    #2 rst_n_w = 1'b1;
    #1 check_eq("wrap0.adrs", imem_adrs_w, 32'hFFFF_FFF8);
    step();
    check_eq("wrap1.adrs", imem_adrs_w, 32'hFFFF_FFFC);
    check_eq("wrap1.inst", if_id_inst_w, 32'h0000_0FF8);
    step();
    check_eq("wrap2.adrs", imem_adrs_w, 32'h0000_0000);
    check_eq("wrap2.inst", if_id_inst_w, 32'h0000_0FFC);
    check_eq("wrap2.ifpc", if_id_pc_w, 32'h0000_0000);
    check_eq("wrap2.valid", {31'b0, if_id_valid_w}, 32'h1);
    step();
    check_eq("wrap3.inst", if_id_inst_w, 32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU.
- Owns the program counter and drives the byte address into the instruction memory.
- Captures the returned word, with its PC+4, into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit freeze, branch/jump redirect from later stages, and IF/ID flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- freeze  in  1  hazard-unit stall; hold PC and IF/ID
- branch_taken  in  1  redirect request from EXE stage
- branch_addr  in  32  redirect target byte address
- flush  in  1  squash IF/ID contents (bubble)
- imem_adrs  out  32  byte address to instruction memory
- imem_inst  in  32  instruction word from memory (combinational)
- if_id_pc  out  32  PC+4 of the captured instruction
- if_id_inst  out  32  captured instruction
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (asynchronous, immediate): pc=RESET_PC, if_id_pc=0, if_id_inst=0 (NOP), if_id_valid=0.
- imem_adrs = pc, combinational from the PC register. Low two bits are always 00.
- Memory latency is 0: imem_inst is valid in the same cycle. The instruction at PC A appears on if_id_inst one clock after pc==A.
- Per-edge priority, highest first:
  1. branch_taken=1 -> pc <= {branch_addr[31:2],2'b00}; IF/ID <= bubble (inst 0, valid 0, pc 0). Overrides freeze and flush.
  2. flush=1 -> IF/ID <= bubble; pc <= pc+PC_STEP if freeze=0, else pc holds.
  3. freeze=1 -> pc and all IF/ID outputs hold unchanged.
  4. Otherwise -> pc <= pc+PC_STEP; if_id_pc <= pc+PC_STEP; if_id_inst <= imem_inst; if_id_valid <= 1.
- Arithmetic: pc+PC_STEP is 32-bit modulo. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Unaligned branch_addr: bits [1:0] are discarded silently.
- Freeze held for N cycles: zero fetches, outputs stable for all N cycles; resumes from the held PC.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of freeze/branch. First fetch after deassertion is from RESET_PC.
- No internal FSM beyond PC + IF/ID registers. All outputs are registered except imem_adrs.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined: adds two outputs, fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every edge taking rule 4.
  - stall_cnt increments on every edge where freeze=1 and branch_taken=0.
  - Both wrap modulo 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - constants XLEN=32, NOP_INST=32'h0000_0000, DEFAULT_RESET_PC=32'h0;
  - typedef if_id_t {pc, inst, valid}, reused by the ID stage.
- One sub-module, pc_reg: async-reset PC register with load-enable and load-value inputs. The redirect/advance mux stays in if_stage.

Test Plan:
- Reset then run 4 cycles, bench memory returns adrs+32'h1000 -> imem_adrs 0,4,8,12; if_id_inst 32'h1000,32'h1004,32'h1008 lagging one cycle; if_id_pc 4,8,12; valid 0 then 1.
- freeze=1 for 3 cycles at pc=8 -> pc stays 8, if_id_inst stays 32'h1004 with if_id_pc 8; after release next capture is 32'h1008.
- branch_taken=1, branch_addr=32'h0000_0043, with freeze=1 same cycle -> next pc=32'h40; IF/ID bubble (valid 0, inst 0); following cycle captures 32'h1040.
- flush=1 alone at pc=16 -> pc becomes 20; if_id_valid=0, if_id_inst=0 for that cycle.
- RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low mid-cycle during freeze at pc=32'h24 -> outputs zero immediately; pc=RESET_PC. With IF_PERF_CNT_EN, fetch_cnt and stall_cnt read 0.
